// File: rtl/mdu_issue_ctrl.sv
// Issue/retire controller in front of the RV32M multiply/divide unit.
// Accepts one M-extension request at a time, resolves divide-by-zero and
// signed-overflow divides locally, otherwise holds operands on the MDU for
// the mode's fixed latency and captures the answer. Results leave through a
// valid/ready handshake; busy stalls the pipeline while not idle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               abort any in-flight or pending operation
//   req_*               request handshake, mode, operands, destination tag
//   mdu_num1/2, mdu_mode  operands and mode driven to the MDU
//   mdu_ans, mdu_error  MDU result and error code (bit 1 = unsupported)
//   res_*               result handshake, data, tag, illegal flag
//   busy                stall to the pipeline
module mdu_issue_ctrl #(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_mode,
  input  logic [31:0] req_num1,
  input  logic [31:0] req_num2,
  input  logic [4:0]  req_rd,
  output logic [31:0] mdu_num1,
  output logic [31:0] mdu_num2,
  output logic [7:0]  mdu_mode,
  input  logic [31:0] mdu_ans,
  input  logic [1:0]  mdu_error,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_rd,
  output logic        res_illegal,
  output logic        busy
);

  localparam int unsigned DW = 32;
  localparam int unsigned MW = 8;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = $clog2(DIV_LAT + 1);

  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_LAT - 1);

  localparam logic [MW-1:0] MODE_DIV  = 8'h44;
  localparam logic [MW-1:0] MODE_DIVU = 8'h45;
  localparam logic [MW-1:0] MODE_REM  = 8'h46;
  localparam logic [MW-1:0] MODE_REMU = 8'h47;

  localparam logic [DW-1:0] INT_MIN = 32'h8000_0000;
  localparam logic [DW-1:0] ALL_ONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          res_valid_d;
  logic [DW-1:0] res_data_d;
  logic [RW-1:0] res_rd_d;
  logic          res_illegal_d;
  logic [DW-1:0] mdu_num1_d;
  logic [DW-1:0] mdu_num2_d;
  logic [MW-1:0] mdu_mode_d;

  logic accept;
  logic mode_legal;
  logic div_zero;
  logic rem_zero;
  logic ovf;
  logic exec_last;

  // Only the unsupported-mode bit of the MDU error code is meaningful here.
  logic unused_err;
  assign unused_err = mdu_error[0];

  assign req_ready = (state_q == S_IDLE) && !flush && !rst;
  assign busy      = (state_q != S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Request classification for the locally resolved cases.
  assign mode_legal = (req_mode[7:3] == 5'b01000);
  assign div_zero   = ((req_mode == MODE_DIV) || (req_mode == MODE_DIVU)) && (req_num2 == '0);
  assign rem_zero   = ((req_mode == MODE_REM) || (req_mode == MODE_REMU)) && (req_num2 == '0);
  assign ovf        = (req_num1 == INT_MIN) && (req_num2 == ALL_ONE);

  // mdu_mode holds the in-flight mode during EXEC, so bit 2 selects divide latency.
  assign exec_last = mdu_mode[2] ? (cnt_q == DIV_LAST) : (cnt_q == MUL_LAST);

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    res_valid_d   = res_valid;
    res_data_d    = res_data;
    res_rd_d      = res_rd;
    res_illegal_d = res_illegal;
    mdu_num1_d    = mdu_num1;
    mdu_num2_d    = mdu_num2;
    mdu_mode_d    = mdu_mode;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          res_rd_d      = req_rd;
          mdu_num1_d    = req_num1;
          mdu_num2_d    = req_num2;
          res_illegal_d = 1'b0;
          res_valid_d   = 1'b1;
          state_d       = S_RESP;
          if (!mode_legal) begin
            res_data_d    = '0;
            res_illegal_d = 1'b1;
          end else if (div_zero) begin
            res_data_d = ALL_ONE;
          end else if (rem_zero) begin
            res_data_d = req_num1;
          end else if ((req_mode == MODE_DIV) && ovf) begin
            res_data_d = INT_MIN;
          end else if ((req_mode == MODE_REM) && ovf) begin
            res_data_d = '0;
          end else begin
            res_valid_d = 1'b0;
            state_d     = S_EXEC;
            cnt_d       = '0;
            mdu_mode_d  = req_mode;
          end
        end
      end

      S_EXEC: begin
        if (exec_last) begin
          res_data_d    = mdu_ans;
          res_illegal_d = mdu_error[1];
          res_valid_d   = 1'b1;
          mdu_mode_d    = '0;
          cnt_d         = '0;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        res_valid_d = 1'b0;
        mdu_mode_d  = '0;
        cnt_d       = '0;
      end
    endcase

    // Flush beats result handshake and EXEC completion.
    if (flush) begin
      state_d     = S_IDLE;
      res_valid_d = 1'b0;
      mdu_mode_d  = '0;
      cnt_d       = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_rd      <= '0;
      res_illegal <= 1'b0;
      mdu_num1    <= '0;
      mdu_num2    <= '0;
      mdu_mode    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_valid   <= res_valid_d;
      res_data    <= res_data_d;
      res_rd      <= res_rd_d;
      res_illegal <= res_illegal_d;
      mdu_num1    <= mdu_num1_d;
      mdu_num2    <= mdu_num2_d;
      mdu_mode    <= mdu_mode_d;
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl: directed corner cases plus random
// requests checked cycle by cycle against a rule-level reference model.
module tb_mdu_issue_ctrl;

  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned DIV_LAT = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_mode;
  logic [31:0] req_num1;
  logic [31:0] req_num2;
  logic [4:0]  req_rd;
  logic [31:0] mdu_num1;
  logic [31:0] mdu_num2;
  logic [7:0]  mdu_mode;
  logic [31:0] mdu_ans;
  logic [1:0]  mdu_error;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        res_illegal;
  logic        busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_data;
  logic        last_ill;
  logic [1:0]  err_drv  = 2'b00;
  int unsigned held     = 0;
  int unsigned mdu_lat;

  typedef struct packed {
    logic [31:0] data;
    logic        ill;
    logic        fast;
  } exp_t;

  mdu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_num1(req_num1), .req_num2(req_num2), .req_rd(req_rd),
    .mdu_num1(mdu_num1), .mdu_num2(mdu_num2), .mdu_mode(mdu_mode),
    .mdu_ans(mdu_ans), .mdu_error(mdu_error),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rd(res_rd), .res_illegal(res_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  // RV32M arithmetic; divide corner cases return 0 since the MDU never sees them.
  function automatic logic [31:0] rv32m(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    r  = '0;
    if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF && (m == 8'h44 || m == 8'h46))) begin
      r = '0;
    end else begin
      case (m)
        8'h40: begin p = ua * ub; r = p[31:0];  end
        8'h41: begin p = sa * sb; r = p[63:32]; end
        8'h42: begin p = sa * ub; r = p[63:32]; end
        8'h43: begin p = ua * ub; r = p[63:32]; end
        8'h44: r = 32'($signed(a) / $signed(b));
        8'h45: r = a / b;
        8'h46: r = 32'($signed(a) % $signed(b));
        8'h47: r = a % b;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // Expected result and whether it bypasses the MDU.
  function automatic exp_t predict(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b, input logic [1:0] er);
    exp_t e;
    logic ov;
    ov     = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    e.fast = 1'b1;
    e.ill  = 1'b0;
    e.data = '0;
    if (m < 8'h40 || m > 8'h47) e.ill = 1'b1;
    else if ((m == 8'h44 || m == 8'h45) && b == 32'd0) e.data = 32'hFFFF_FFFF;
    else if ((m == 8'h46 || m == 8'h47) && b == 32'd0) e.data = a;
    else if (m == 8'h44 && ov) e.data = 32'h8000_0000;
    else if (m == 8'h46 && ov) e.data = 32'd0;
    else begin
      e.fast = 1'b0;
      e.data = rv32m(m, a, b);
      e.ill  = er[1];
    end
    return e;
  endfunction

  // MDU model: answer is valid only once the inputs have been held for the full latency.
  always @(posedge clk) held <= (mdu_mode != 8'h00) ? held + 1 : 0;

  always_comb begin
    mdu_lat = mdu_mode[2] ? DIV_LAT : MUL_LAT;
    if (mdu_mode != 8'h00 && held == mdu_lat - 1) mdu_ans = rv32m(mdu_mode, mdu_num1, mdu_num2);
    else mdu_ans = 32'hDEAD_BEEF ^ held;
  end

  assign mdu_error = err_drv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request from an IDLE cycle through its handshake, checked every cycle.
  task automatic do_txn(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [1:0] er, input int hold);
    exp_t        e;
    int unsigned lat;
    e       = predict(m, a, b, er);
    lat     = m[2] ? DIV_LAT : MUL_LAT;
    err_drv = er;
    req_mode = m; req_num1 = a; req_num2 = b; req_rd = rd; req_valid = 1'b1;
    check("idle_req_ready", 32'(req_ready), 32'd1);
    step();
    // Garbage requests while busy must be ignored.
    req_valid = 1'($urandom_range(0, 1));
    req_mode  = 8'($urandom);
    req_num1  = $urandom;
    req_num2  = $urandom;
    req_rd    = 5'($urandom);
    if (!e.fast) begin
      for (int c = 1; c <= int'(lat); c++) begin
        check("exec_busy",  32'(busy), 32'd1);
        check("exec_valid", 32'(res_valid), 32'd0);
        check("exec_mode",  32'(mdu_mode), 32'(m));
        check("exec_num1",  mdu_num1, a);
        check("exec_num2",  mdu_num2, b);
        step();
      end
    end
    for (int k = 0; k <= hold; k++) begin
      check("resp_valid",   32'(res_valid), 32'd1);
      check("resp_data",    res_data, e.data);
      check("resp_rd",      32'(res_rd), 32'(rd));
      check("resp_illegal", 32'(res_illegal), 32'(e.ill));
      check("resp_busy",    32'(busy), 32'd1);
      check("resp_ready",   32'(req_ready), 32'd0);
      check("resp_mode",    32'(mdu_mode), 32'd0);
      last_data = res_data;
      last_ill  = res_illegal;
      if (k == hold) begin
        res_ready = 1'b1;
        req_valid = 1'b0;
      end
      step();
    end
    res_ready = 1'b0;
    check("after_valid", 32'(res_valid), 32'd0);
    check("after_ready", 32'(req_ready), 32'd1);
    check("after_busy",  32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0]  m;
    logic [31:0] a, b;
    logic [1:0]  er;
    logic        seen;

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
    req_mode = '0; req_num1 = '0; req_num2 = '0; req_rd = '0;
    step();
    step();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data",  res_data, 32'd0);
    check("rst_mdu_mode",  32'(mdu_mode), 32'd0);
    check("rst_mdu_num1",  mdu_num1, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // Directed cases.
    do_txn(8'h40, 32'd7, 32'd6, 5'd17, 2'b00, 0);
    check("mul_7x6", last_data, 32'd42);
    do_txn(8'h44, 32'd5, 32'd0, 5'd1, 2'b00, 0);
    check("div_by_zero", last_data, 32'hFFFF_FFFF);
    do_txn(8'h47, 32'd5, 32'd0, 5'd2, 2'b00, 0);
    check("remu_by_zero", last_data, 32'd5);
    do_txn(8'h44, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 2'b00, 0);
    check("div_ovf", last_data, 32'h8000_0000);
    do_txn(8'h46, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 2'b00, 0);
    check("rem_ovf", last_data, 32'd0);
    do_txn(8'h30, 32'd9, 32'd9, 5'd5, 2'b00, 0);
    check("illegal_mode", 32'(last_ill), 32'd1);
    do_txn(8'h43, 32'd3, 32'd4, 5'd6, 2'b11, 0);
    check("mdu_unsupported", 32'(last_ill), 32'd1);
    do_txn(8'h44, 32'd100, 32'd7, 5'd7, 2'b00, 5);
    check("div_backpressure", last_data, 32'd14);

    // Flush in EXEC cycle 10 of a DIV: no result appears.
    err_drv = 2'b00;
    req_mode = 8'h44; req_num1 = 32'd100; req_num2 = 32'd7; req_rd = 5'd8; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (9) step();
    check("flush_exec_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    #1;
    check("flush_req_ready", 32'(req_ready), 32'd0);
    step();
    flush = 1'b0;
    #1;
    check("flush_busy",  32'(busy), 32'd0);
    check("flush_valid", 32'(res_valid), 32'd0);
    check("flush_mode",  32'(mdu_mode), 32'd0);
    check("flush_ready", 32'(req_ready), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      step();
      if (res_valid) seen = 1'b1;
    end
    check("flush_no_result", 32'(seen), 32'd0);

    // Flush with a request in IDLE: not accepted.
    flush = 1'b1; req_valid = 1'b1; req_mode = 8'h45; req_num1 = 32'd3; req_num2 = 32'd0;
    #1;
    check("flush_idle_ready", 32'(req_ready), 32'd0);
    step();
    flush = 1'b0; req_valid = 1'b0;
    check("flush_idle_valid", 32'(res_valid), 32'd0);
    check("flush_idle_busy",  32'(busy), 32'd0);

    // Reset while in RESP.
    req_mode = 8'h47; req_num1 = 32'd5; req_num2 = 32'd0; req_rd = 5'd9; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check("rresp_valid", 32'(res_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rresp_req_ready", 32'(req_ready), 32'd0);
    check("rresp_busy",      32'(busy), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("rresp_res_valid", 32'(res_valid), 32'd0);
    check("rresp_res_data",  res_data, 32'd0);
    check("rresp_res_rd",    32'(res_rd), 32'd0);
    check("rresp_illegal",   32'(res_illegal), 32'd0);
    check("rresp_num1",      mdu_num1, 32'd0);
    check("rresp_num2",      mdu_num2, 32'd0);
    check("rresp_mode",      32'(mdu_mode), 32'd0);
    check("rresp_idle",      32'(req_ready), 32'd1);

    // Reset mid-EXEC discards the operation.
    req_mode = 8'h45; req_num1 = 32'd50; req_num2 = 32'd3; req_rd = 5'd10; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rexec_busy",  32'(busy), 32'd0);
    check("rexec_mode",  32'(mdu_mode), 32'd0);
    check("rexec_valid", 32'(res_valid), 32'd0);
    do_txn(8'h45, 32'd50, 32'd3, 5'd11, 2'b00, 1);

    // Randomized requests.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) == 9) m = 8'($urandom);
      else m = 8'h40 + 8'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      if ($urandom_range(0, 5) == 0) er = 2'b10 | 2'($urandom_range(0, 1));
      else er = 2'($urandom_range(0, 1));
      do_txn(m, a, b, 5'($urandom), er, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
